// File: rtl/reaction_game_pkg.sv
// Shared types for the reaction game: game phase and difficulty mode encodings.
package reaction_game_pkg;

  typedef enum logic [1:0] {
    StSetup  = 2'd0,
    StTarget = 2'd1,
    StCount  = 2'd2,
    StResult = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ModeEasy = 2'd0,
    ModeReg  = 2'd1,
    ModeHard = 2'd2
  } mode_e;

  localparam logic [1:0] MODE_MAX = 2'd2;

endpackage

// File: rtl/led_bar_encode.sv
// Registered score-to-LED-bar encoder. One LED goes dark per BUCKET score units;
// the bar is blank while not enabled or when clr is asserted.
module led_bar_encode #(
  parameter int unsigned NUM_W  = 14,
  parameter int unsigned LED_N  = 16,
  parameter int unsigned BUCKET = 30
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [NUM_W-1:0] score_i,
  output logic [LED_N-1:0] led_o
);

  if (BUCKET == 0) begin : g_bad_bucket
    $error("BUCKET must be non-zero");
  end

  logic [NUM_W-1:0] off;
  logic [LED_N-1:0] bar;
  logic [LED_N-1:0] led_d, led_q;

  // Number of extinguished LEDs, low end first.
  always_comb begin
    off = score_i / NUM_W'(BUCKET);
    bar = '0;
    if (32'(off) < LED_N) begin
      bar = {LED_N{1'b1}} << off;
    end
  end

  // Bar shows only while the score is valid; clr blanks it on the leaving edge.
  always_comb begin
    led_d = '0;
    if (en_i && !clr_i) begin
      led_d = bar;
    end
  end

  // Bar register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/reaction_game_core.sv
// Reaction game control: difficulty select, target capture, timed count-up and
// scored result on an LED bar. Optional best-score tracking via BEST_SCORE_EN.
module reaction_game_core
  import reaction_game_pkg::*;
#(
  parameter int unsigned NUM_W      = 14,
  parameter int unsigned LED_N      = 16,
  parameter int unsigned TICK_W     = 20,
  parameter int unsigned TICKS_EASY = 1000000,
  parameter int unsigned TICKS_REG  = 200000,
  parameter int unsigned TICKS_HARD = 100000,
  parameter int unsigned BUCKET     = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  input  logic [NUM_W-1:0] rand_num,   // free-running random value
  output logic [1:0]       phase,
  output logic [1:0]       mode,
  output logic [NUM_W-1:0] number,
  output logic [NUM_W-1:0] score,
  output logic             score_valid,
  output logic [LED_N-1:0] led,
  output logic [NUM_W-1:0] best_score,
  output logic             new_best
);

  if (TICKS_EASY < 2 || TICKS_REG < 2 || TICKS_HARD < 2) begin : g_ticks_too_small
    $error("TICKS_EASY/TICKS_REG/TICKS_HARD must all be at least 2");
  end

  if (64'(TICKS_EASY) > (64'd1 << TICK_W) || 64'(TICKS_REG) > (64'd1 << TICK_W) ||
      64'(TICKS_HARD) > (64'd1 << TICK_W)) begin : g_ticks_too_wide
    $error("TICK_W too narrow for the configured TICKS_* values");
  end

  logic up_prev_q, down_prev_q, sel_prev_q;
  logic up_edge, down_edge, sel_edge;

  phase_e           phase_d, phase_q;
  logic [1:0]       mode_d, mode_q;
  logic [NUM_W-1:0] number_d, number_q;
  logic [NUM_W-1:0] target_d, target_q;
  logic [NUM_W-1:0] score_d, score_q;
  logic             score_valid_d, score_valid_q;
  logic [TICK_W-1:0] tick_d, tick_q, tick_max;
  logic             led_clr;

  assign up_edge   = btn_up & ~up_prev_q;
  assign down_edge = btn_down & ~down_prev_q;
  assign sel_edge  = btn_sel & ~sel_prev_q;

  // Previous-value registers reset high so a button held through reset cannot
  // fire a spurious edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_prev_q   <= 1'b1;
      down_prev_q <= 1'b1;
      sel_prev_q  <= 1'b1;
    end else begin
      up_prev_q   <= btn_up;
      down_prev_q <= btn_down;
      sel_prev_q  <= btn_sel;
    end
  end

  // Terminal prescaler count for the current difficulty.
  always_comb begin
    unique case (mode_q)
      ModeEasy: tick_max = TICK_W'(TICKS_EASY - 1);
      ModeReg:  tick_max = TICK_W'(TICKS_REG - 1);
      default:  tick_max = TICK_W'(TICKS_HARD - 1);
    endcase
  end

  // Game FSM next-state and datapath updates.
  always_comb begin
    phase_d       = phase_q;
    mode_d        = mode_q;
    number_d      = number_q;
    target_d      = target_q;
    score_d       = score_q;
    score_valid_d = score_valid_q;
    tick_d        = tick_q;
    led_clr       = 1'b0;
    unique case (phase_q)
      StSetup: begin
        if (sel_edge) begin
          phase_d  = StTarget;
          target_d = (rand_num == '0) ? NUM_W'(1) : rand_num;
          number_d = (rand_num == '0) ? NUM_W'(1) : rand_num;
        end else if (up_edge && !down_edge) begin
          if (mode_q != MODE_MAX) mode_d = mode_q + 2'd1;
        end else if (down_edge && !up_edge) begin
          if (mode_q != 2'd0) mode_d = mode_q - 2'd1;
        end
      end
      StTarget: begin
        if (sel_edge) begin
          phase_d  = StCount;
          number_d = '0;
          tick_d   = '0;
        end
      end
      StCount: begin
        if (sel_edge) begin
          phase_d       = StResult;
          score_d       = (number_q >= target_q) ? number_q - target_q : target_q - number_q;
          score_valid_d = 1'b1;
        end else if (tick_q == tick_max) begin
          tick_d = '0;
          if (number_q != '1) number_d = number_q + NUM_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      StResult: begin
        if (sel_edge) begin
          phase_d       = StSetup;
          score_valid_d = 1'b0;
          number_d      = '0;
          target_d      = '0;
          led_clr       = 1'b1;
        end
      end
      default: phase_d = StSetup;
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= StSetup;
      mode_q        <= ModeReg;
      number_q      <= '0;
      target_q      <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      tick_q        <= '0;
    end else begin
      phase_q       <= phase_d;
      mode_q        <= mode_d;
      number_q      <= number_d;
      target_q      <= target_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      tick_q        <= tick_d;
    end
  end

  led_bar_encode #(
    .NUM_W  (NUM_W),
    .LED_N  (LED_N),
    .BUCKET (BUCKET)
  ) u_led_bar_encode (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (score_valid_q),
    .clr_i   (led_clr),
    .score_i (score_q),
    .led_o   (led)
  );

`ifdef BEST_SCORE_EN
  logic             result_entry;
  logic [NUM_W-1:0] best_d, best_q;
  logic             new_best_d, new_best_q;

  assign result_entry = (phase_q == StCount) && sel_edge;

  // Track the lowest score since reset; pulse new_best on improvement.
  always_comb begin
    best_d     = best_q;
    new_best_d = 1'b0;
    if (result_entry && (score_d < best_q)) begin
      best_d     = score_d;
      new_best_d = 1'b1;
    end
  end

  // Best-score registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q     <= '1;
      new_best_q <= 1'b0;
    end else begin
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign best_score = best_q;
  assign new_best   = new_best_q;
`else
  assign best_score = '1;
  assign new_best   = 1'b0;
`endif

  assign phase       = phase_q;
  assign mode        = mode_q;
  assign number      = number_q;
  assign score       = score_q;
  assign score_valid = score_valid_q;

endmodule
